// File: rtl/fifo_drain_arb.sv
// Round-robin read scheduler draining NCH synchronous FIFOs into one valid/ready stream.
// Each grant serves a channel for up to BURST words, then the search pointer moves past it.
module fifo_drain_arb #(
  parameter int NCH        = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST      = 4,
  localparam int CW        = $clog2(NCH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [NCH-1:0]            i_empty,
  input  logic [NCH*DATA_WIDTH-1:0] i_data,
  output logic [NCH-1:0]            o_rd,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic [CW-1:0]             o_chan,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_busy
);

  localparam int CNTW = $clog2(BURST + 1);

  typedef enum logic {
    IDLE,
    SERVE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cur_q, cur_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         chan_q, chan_d;
  logic                  valid_q, valid_d;

  logic                  load;
  logic                  rdEn;
  logic                  burstDone;
  logic                  found;
  logic [CW-1:0]         pick;
  logic [CW:0]           searchSum;
  logic [CW-1:0]         searchIdx;
  logic [CW-1:0]         curNext;
  logic [DATA_WIDTH-1:0] chData [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_split
    assign chData[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign load      = !valid_q || i_ready;
  assign burstDone = (cnt_q == CNTW'(BURST - 1));
  assign curNext   = (cur_q == CW'(NCH - 1)) ? '0 : cur_q + 1'b1;

  // Reset gates the strobe so no FIFO word is consumed on a reset edge.
  assign rdEn = (state_q == SERVE) && i_en && load && !i_empty[cur_q] && !i_rst;

  always_comb begin
    o_rd = '0;
    if (rdEn) begin
      o_rd = NCH'(1) << cur_q;
    end
  end

  // First non-empty channel starting at ptr, wrapping modulo NCH (NCH need not be 2^n).
  always_comb begin
    found     = 1'b0;
    pick      = ptr_q;
    searchSum = '0;
    searchIdx = '0;
    for (int i = 0; i < NCH; i++) begin
      searchSum = {1'b0, ptr_q} + (CW + 1)'(i);
      if (searchSum >= (CW + 1)'(NCH)) begin
        searchSum = searchSum - (CW + 1)'(NCH);
      end
      searchIdx = searchSum[CW-1:0];
      if (!found && !i_empty[searchIdx]) begin
        found = 1'b1;
        pick  = searchIdx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (i_en && found) begin
          cur_d   = pick;
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (rdEn) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!i_en || i_empty[cur_q] || (rdEn && burstDone)) begin
          state_d = IDLE;
          ptr_d   = curNext;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh read always refills the output register; otherwise an accepted word retires.
    if (rdEn) begin
      data_d  = chData[cur_q];
      chan_d  = cur_q;
      valid_d = 1'b1;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_chan  = chan_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q == SERVE);

endmodule

// File: doc/fifo_drain_arb.md
Name: fifo_drain_arb

Overview:
Round-robin read scheduler that drains NCH fifo_sync instances into one valid/ready output stream. It drives each FIFO's read strobe from that FIFO's empty flag. Each granted channel is served for up to BURST words before the grant rotates. The block sits between the per-source FIFO bank and a single downstream consumer, such as a packer or DMA write port.

Parameters:
NCH, 4, number of FIFO channels; must be at least 2, and need not be a power of two.
DATA_WIDTH, 32, FIFO word width.
BURST, 4, maximum words drained per grant; must be at least 1.
CW, $clog2(NCH), derived width of a channel index; not overridable.

Ports:
i_clk  in  1  clock; all state is updated on the rising edge.
i_rst  in  1  synchronous active-high reset.
i_en  in  1  scheduler enable; when low, no new grants are made and no reads are issued.
i_empty  in  NCH  per-channel o_empty from each FIFO (registered in the FIFO).
i_data  in  NCH*DATA_WIDTH  per-channel FIFO o_data, concatenated; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
o_rd  out  NCH  per-channel i_rd strobes; combinational; at most one bit is high at a time.
o_data  out  DATA_WIDTH  registered output word.
o_chan  out  CW  registered channel index of o_data.
o_valid  out  1  o_data and o_chan are valid.
i_ready  in  1  downstream accepts the word when o_valid and i_ready are both high.
o_busy  out  1  high while the state is SERVE.

Behaviour:
- Reset (i_rst high at an edge) clears all state:
  - state=IDLE, ptr=0, cur=0, cnt=0.
  - o_valid=0, o_data=0, o_chan=0.
  - o_rd=0 combinationally during the reset cycle.
  - Reset has priority over all other events, including mid-burst. A held output word is discarded; the FIFOs are not touched.
- FIFO read model: a FIFO's o_data is its head word whenever its empty flag is low. Asserting o_rd[k] for one cycle consumes that word at the edge. The FIFO's empty flag reflects the consumption on the next cycle.
- Output register load condition: load = !o_valid || i_ready.
- State IDLE:
  - If i_en is high and any bit of i_empty is low, choose the first non-empty channel found by searching ptr, ptr+1, … wrapping modulo NCH.
  - Set cur to that channel, cnt=0, and go to SERVE.
  - No read is issued in the IDLE cycle, so arbitration costs 1 cycle.
- State SERVE, read strobe: o_rd[cur] = i_en && load && !i_empty[cur]. All other o_rd bits are 0.
- State SERVE, on a read:
  - o_data <= i_data[cur], o_chan <= cur, o_valid <= 1, cnt <= cnt+1.
- State SERVE, exit to IDLE with ptr <= (cur+1) mod NCH when any of the following holds:
  - a read occurs with cnt == BURST-1 (burst done);
  - i_empty[cur] is high, regardless of load; no read is issued that cycle;
  - i_en is low; no read is issued that cycle.
- Otherwise SERVE holds. This includes backpressure (load low): no read, and cnt is held.
- o_valid clears when i_ready is high and no read occurs that cycle. o_data and o_chan hold whenever o_valid is high and i_ready is low.
- Invariants:
  - o_rd[k] is never high while i_empty[k] is high.
  - No word is lost or duplicated.
  - Words from one channel leave the block in FIFO order.
- Throughput with i_ready held high: 1 word per cycle within a burst, plus 1 bubble per grant.
  - A FIFO that empties mid-burst costs 1 extra cycle, because its empty flag lags the read by one cycle.
- Starvation: every channel that stays non-empty is granted within NCH grants.
- cnt width is $clog2(BURST+1); it is cleared on every grant.

Test Plan:
1. Reset: hold i_rst high for 2 cycles with all FIFOs non-empty -> o_rd=0, o_valid=0, o_data=0, o_chan=0, o_busy=0 in both cycles and the first cycle after reset.
2. Single channel, BURST=4, i_ready=1, ch2 holding A,B,C:
   - cycle 0: IDLE grants ch2;
   - cycles 1-3: o_rd[2] high;
   - cycles 2-4: o_valid high with A,B,C and o_chan=2;
   - then o_busy falls and ptr=3.
3. Rotation, all 4 channels holding 8 words each, BURST=4, i_ready=1 -> output order ch0×4, ch1×4, ch2×4, ch3×4, ch0×4, …; 32 words total; exactly one bubble between bursts.
4. Backpressure: drop i_ready while o_valid=1 for 5 cycles -> o_rd all 0 and o_data/o_chan stable; after release, the sequence resumes with no loss or duplication.
5. Enable drop: deassert i_en after 2 words of a ch1 burst -> no further o_rd, state goes IDLE with ptr=2; after re-enable, ch2 is granted first if it is non-empty.
6. Empty gating: random i_empty/i_ready over 10k cycles against a scoreboard model -> o_rd never coincides with i_empty; per-channel order is preserved; the onehot0(o_rd) check holds.
